// File: rtl/mips_commit_monitor.sv
// rtl/mips_commit_monitor.sv - serialises GRF/DM commit events into a FIFO for a checker
// GRF (W stage) is older than DM (M stage), so it always takes the first free slot.
module mips_commit_monitor #(
  parameter int DEPTH     = 16,
  parameter int DROP_ZERO = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        grf_we,
  input  logic [31:0] grf_pc,
  input  logic [4:0]  grf_addr,
  input  logic [31:0] grf_wdata,
  input  logic        dm_we,
  input  logic [31:0] dm_pc,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_kind,
  output logic [31:0] out_pc,
  output logic [31:0] out_addr,
  output logic [31:0] out_data,
  output logic        overflow,
  output logic [31:0] event_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int FW = CW + 1;

  logic              mem_kind_q [DEPTH];
  logic              mem_kind_d [DEPTH];
  logic [31:0]       mem_pc_q   [DEPTH];
  logic [31:0]       mem_pc_d   [DEPTH];
  logic [31:0]       mem_addr_q [DEPTH];
  logic [31:0]       mem_addr_d [DEPTH];
  logic [31:0]       mem_data_q [DEPTH];
  logic [31:0]       mem_data_d [DEPTH];

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     occ_q, occ_d;
  logic              overflow_q, overflow_d;
  logic [31:0]       event_count_q, event_count_d;

  logic              pop;
  logic              grf_cand;
  logic              dm_cand;
  logic              grf_acc;
  logic              dm_acc;
  logic [FW-1:0]     free_slots;
  logic [FW-1:0]     dm_need;
  logic [1:0]        n_acc;
  logic [PW-1:0]     dm_slot;

  always_comb begin
    pop        = (occ_q != '0) && out_ready;
    grf_cand   = grf_we && !((DROP_ZERO != 0) && (grf_addr == 5'd0));
    dm_cand    = dm_we;
    // A slot vacated by this cycle's pop is reusable by this cycle's push.
    free_slots = FW'(DEPTH) - FW'(occ_q) + FW'(pop);
    grf_acc    = grf_cand && (free_slots != '0);
    dm_need    = grf_acc ? FW'(2) : FW'(1);
    dm_acc     = dm_cand && (free_slots >= dm_need);
    n_acc      = {1'b0, grf_acc} + {1'b0, dm_acc};
    dm_slot    = wr_ptr_q + PW'(grf_acc);

    mem_kind_d = mem_kind_q;
    mem_pc_d   = mem_pc_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;

    if (grf_acc) begin
      mem_kind_d[wr_ptr_q] = 1'b0;
      mem_pc_d[wr_ptr_q]   = grf_pc;
      mem_addr_d[wr_ptr_q] = {27'b0, grf_addr};
      mem_data_d[wr_ptr_q] = grf_wdata;
    end
    if (dm_acc) begin
      mem_kind_d[dm_slot] = 1'b1;
      mem_pc_d[dm_slot]   = dm_pc;
      mem_addr_d[dm_slot] = dm_addr;
      mem_data_d[dm_slot] = dm_wdata;
    end

    wr_ptr_d      = wr_ptr_q + PW'(n_acc);
    rd_ptr_d      = rd_ptr_q + PW'(pop);
    occ_d         = occ_q + CW'(n_acc) - CW'(pop);
    event_count_d = event_count_q + 32'(n_acc);
    overflow_d    = overflow_q || (grf_cand && !grf_acc) || (dm_cand && !dm_acc);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_kind_q    <= '{default: '0};
      mem_pc_q      <= '{default: '0};
      mem_addr_q    <= '{default: '0};
      mem_data_q    <= '{default: '0};
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      occ_q         <= '0;
      overflow_q    <= 1'b0;
      event_count_q <= '0;
    end else begin
      mem_kind_q    <= mem_kind_d;
      mem_pc_q      <= mem_pc_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_q    <= mem_data_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      occ_q         <= occ_d;
      overflow_q    <= overflow_d;
      event_count_q <= event_count_d;
    end
  end

  // Head fields come straight from storage, so they hold until the pointer moves.
  assign out_valid   = (occ_q != '0);
  assign out_kind    = mem_kind_q[rd_ptr_q];
  assign out_pc      = mem_pc_q[rd_ptr_q];
  assign out_addr    = mem_addr_q[rd_ptr_q];
  assign out_data    = mem_data_q[rd_ptr_q];
  assign overflow    = overflow_q;
  assign event_count = event_count_q;

endmodule

// File: tb/tb_mips_commit_monitor.sv
// tb/tb_mips_commit_monitor.sv - directed self-checking bench for mips_commit_monitor
module tb_mips_commit_monitor;

  logic        clk;
  logic        rst;
  logic        grf_we;
  logic [31:0] grf_pc;
  logic [4:0]  grf_addr;
  logic [31:0] grf_wdata;
  logic        dm_we;
  logic [31:0] dm_pc;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        out_valid;
  logic        out_ready;
  logic        out_kind;
  logic [31:0] out_pc;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic        overflow;
  logic [31:0] event_count;

  int checks;
  int errors;

  mips_commit_monitor #(.DEPTH(16), .DROP_ZERO(1)) dut (
    .clk(clk), .reset(rst),
    .grf_we(grf_we), .grf_pc(grf_pc), .grf_addr(grf_addr), .grf_wdata(grf_wdata),
    .dm_we(dm_we), .dm_pc(dm_pc), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
    .out_pc(out_pc), .out_addr(out_addr), .out_data(out_data),
    .overflow(overflow), .event_count(event_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    grf_we = 0; grf_pc = 0; grf_addr = 0; grf_wdata = 0;
    dm_we = 0; dm_pc = 0; dm_addr = 0; dm_wdata = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    out_ready = 0;
    rst = 1;
    step();
    rst = 0;
  endtask

  task automatic drive_grf(input logic [31:0] pc, input logic [4:0] a, input logic [31:0] d);
    grf_we = 1; grf_pc = pc; grf_addr = a; grf_wdata = d;
  endtask

  task automatic drive_dm(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] d);
    dm_we = 1; dm_pc = pc; dm_addr = a; dm_wdata = d;
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    out_ready = 0;
    #2;
    checks++;
    if ({out_valid, overflow, event_count} !== 34'd0) begin
      errors++;
      $display("FAIL reset_ctrl: valid=%0b ovf=%0b cnt=%0d, required 0 0 0", out_valid, overflow, event_count);
    end
    checks++;
    if ({out_kind, out_pc, out_addr, out_data} !== 97'd0) begin
      errors++;
      $display("FAIL reset_fields: kind=%0b pc=%h addr=%h data=%h, required all 0", out_kind, out_pc, out_addr, out_data);
    end
    step();
    rst = 0;
  endtask

  task automatic test_single_grf();
    apply_reset();
    drive_grf(32'h3000, 5'd8, 32'h1234);
    step();
    idle_inputs();
    checks++;
    if (out_valid !== 1'b1 || out_kind !== 1'b0 || out_addr !== 32'd8 || out_data !== 32'h1234 ||
        out_pc !== 32'h3000 || event_count !== 32'd1) begin
      errors++;
      $display("FAIL single_grf: valid=%0b kind=%0b pc=%h addr=%h data=%h cnt=%0d, required 1 0 3000 8 1234 1",
               out_valid, out_kind, out_pc, out_addr, out_data, event_count);
    end
    out_ready = 1;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_grf_pop: valid=%0b, required 0", out_valid);
    end
  endtask

  task automatic test_dual_write();
    apply_reset();
    out_ready = 1;
    drive_grf(32'h3008, 5'd2, 32'd5);
    drive_dm(32'h300C, 32'h10, 32'd7);
    step();
    idle_inputs();
    checks++;
    if (out_valid !== 1'b1 || out_kind !== 1'b0 || out_pc !== 32'h3008 || out_addr !== 32'd2 ||
        out_data !== 32'd5 || event_count !== 32'd2) begin
      errors++;
      $display("FAIL dual_first: valid=%0b kind=%0b pc=%h addr=%h data=%h cnt=%0d, required 1 0 3008 2 5 2",
               out_valid, out_kind, out_pc, out_addr, out_data, event_count);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_kind !== 1'b1 || out_pc !== 32'h300C || out_addr !== 32'h10 ||
        out_data !== 32'd7) begin
      errors++;
      $display("FAIL dual_second: valid=%0b kind=%0b pc=%h addr=%h data=%h, required 1 1 300c 10 7",
               out_valid, out_kind, out_pc, out_addr, out_data);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL dual_empty: valid=%0b ovf=%0b, required 0 0", out_valid, overflow);
    end
  endtask

  task automatic test_zero_reg();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive_grf(32'h3100 + 32'(4 * i), 5'd0, 32'hDEAD0000 + 32'(i));
      step();
      checks++;
      if (out_valid !== 1'b0 || event_count !== 32'd0) begin
        errors++;
        $display("FAIL zero_reg[%0d]: valid=%0b cnt=%0d, required 0 0", i, out_valid, event_count);
      end
    end
    idle_inputs();
  endtask

  task automatic test_fill_overflow();
    apply_reset();
    for (int i = 1; i <= 17; i++) begin
      drive_grf(32'h3000 + 32'(4 * i), 5'(i % 31 + 1), 32'(i));
      if (i == 17) begin
        checks++;
        if (overflow !== 1'b0 || event_count !== 32'd16) begin
          errors++;
          $display("FAIL fill_full: ovf=%0b cnt=%0d, required 0 16", overflow, event_count);
        end
      end
      step();
    end
    idle_inputs();
    checks++;
    if (overflow !== 1'b1 || event_count !== 32'd16) begin
      errors++;
      $display("FAIL fill_overflow: ovf=%0b cnt=%0d, required 1 16", overflow, event_count);
    end
    out_ready = 1;
    for (int i = 1; i <= 16; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'(i)) begin
        errors++;
        $display("FAIL drain[%0d]: valid=%0b data=%0d, required 1 %0d", i, out_valid, out_data, i);
      end
      step();
    end
    checks++;
    if (out_valid !== 1'b0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL drain_end: valid=%0b ovf=%0b, required 0 1", out_valid, overflow);
    end
  endtask

  task automatic test_full_pop();
    int count;
    logic [31:0] last;
    logic seen_dm;
    apply_reset();
    for (int i = 1; i <= 16; i++) begin
      drive_grf(32'h4000 + 32'(4 * i), 5'd3, 32'(100 + i));
      step();
    end
    out_ready = 1;
    drive_grf(32'h5000, 5'd4, 32'hAA);
    drive_dm(32'h5004, 32'h20, 32'hBB);
    step();
    idle_inputs();
    out_ready = 0;
    checks++;
    if (overflow !== 1'b1 || event_count !== 32'd17 || out_data !== 32'd102) begin
      errors++;
      $display("FAIL full_pop: ovf=%0b cnt=%0d head=%0d, required 1 17 102", overflow, event_count, out_data);
    end
    out_ready = 1;
    count = 0;
    last = 0;
    seen_dm = 0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid) begin
        count++;
        last = out_data;
        if (out_kind) seen_dm = 1;
      end
      step();
    end
    checks++;
    if (count !== 16 || last !== 32'hAA || seen_dm !== 1'b0) begin
      errors++;
      $display("FAIL full_pop_drain: count=%0d last=%h dm_seen=%0b, required 16 aa 0", count, last, seen_dm);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      drive_grf(32'h6000 + 32'(4 * i), 5'd9, 32'(10 + i));
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'(10 + i)) begin
        errors++;
        $display("FAIL b2b[%0d]: valid=%0b data=%0d, required 1 %0d", i, out_valid, out_data, 10 + i);
      end
    end
    idle_inputs();
    drive_dm(32'h6010, 32'h44, 32'h99);
    step();
    idle_inputs();
    checks++;
    if (out_valid !== 1'b1 || out_kind !== 1'b1 || out_addr !== 32'h44 || event_count !== 32'd5) begin
      errors++;
      $display("FAIL b2b_dm: valid=%0b kind=%0b addr=%h cnt=%0d, required 1 1 44 5",
               out_valid, out_kind, out_addr, event_count);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_empty: valid=%0b, required 0", out_valid);
    end
  endtask

  task automatic test_midstream_reset();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive_grf(32'h7000 + 32'(4 * i), 5'd5, 32'(i + 1));
      step();
    end
    idle_inputs();
    checks++;
    if (out_valid !== 1'b1 || event_count !== 32'd5) begin
      errors++;
      $display("FAIL mid_pre: valid=%0b cnt=%0d, required 1 5", out_valid, event_count);
    end
    #2;
    rst = 1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || overflow !== 1'b0 || event_count !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset: valid=%0b ovf=%0b cnt=%0d, required 0 0 0", out_valid, overflow, event_count);
    end
    #1;
    rst = 0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_after: valid=%0b, required 0", out_valid);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_grf();
    test_dual_write();
    test_zero_reg();
    test_fill_overflow();
    test_full_pop();
    test_back_to_back();
    test_midstream_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
